// File: rtl/cache_pkg.sv
// Shared defaults, state encodings and way op codes for the cache sequencer.
package cache_pkg;

  localparam int DEF_TAG_W   = 5;
  localparam int DEF_WORD_W  = 2;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMP,
    S_VICT,
    S_WB,
    S_FILL_RD,
    S_FILL_WR,
    S_REPLAY,
    S_DONE
  } ctrl_state_e;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_REQ,
    HS_REL
  } hs_state_e;

  typedef enum logic [1:0] {
    CMP_RD,
    CMP_WR,
    ACC_RD,
    ACC_WR
  } way_op_e;

  function automatic way_op_e cmp_op(input logic wr);
    return wr ? CMP_WR : CMP_RD;
  endfunction

endpackage

// File: rtl/cache_hs_master.sv
// Four-phase req/ack master: raises the strobe on start, pulses done when ack is
// seen, then waits for ack to fall. Each wait on an ack edge is bounded by TIMEOUT.
module cache_hs_master
  import cache_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ack,
  output logic strobe,
  output logic done,
  output logic timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  hs_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter restarts on every strobe edge, so it times each ack edge separately.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    done    = 1'b0;
    timeout = 1'b0;
    case (state_q)
      HS_IDLE: begin
        cnt_d = '0;
        if (start) state_d = HS_REQ;
      end
      HS_REQ: begin
        if (ack) begin
          done    = 1'b1;
          state_d = HS_REL;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = HS_IDLE;
          cnt_d   = '0;
        end
      end
      HS_REL: begin
        if (!ack) begin
          state_d = HS_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = HS_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = HS_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign strobe = (state_q == HS_REQ);

endmodule

// File: rtl/cache_ctrl.sv
// Cache sequencer: compare, victim read, dirty write-back, refill and replay
// between the CPU port and a single way, using two four-phase masters.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int TAG_W   = DEF_TAG_W,
  parameter int WORD_W  = DEF_WORD_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic                    cpu_wr,
  input  logic [TAG_W+WORD_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic                    cpu_ack,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_hit,
  output logic                    cpu_err,
  output logic                    way_en,
  output logic                    way_comp,
  output logic                    way_write,
  output logic [WORD_W-1:0]       way_word,
  output logic [TAG_W-1:0]        way_tag,
  output logic [DATA_W-1:0]       way_data,
  output logic                    way_valid,
  input  logic                    way_ack,
  input  logic                    way_hit,
  input  logic                    way_dirty,
  input  logic [TAG_W-1:0]        way_tag_out,
  input  logic [DATA_W-1:0]       way_data_out,
  input  logic                    way_valid_out,
  output logic                    mem_req,
  output logic                    mem_wr,
  output logic [TAG_W+WORD_W-1:0] mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic                    mem_ack,
  input  logic [DATA_W-1:0]       mem_rdata
);

  localparam int                LINE_W = 2 ** WORD_W;
  localparam logic [WORD_W-1:0] LAST   = '1;

  ctrl_state_e       state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              req_wr_q, req_wr_d;
  logic [TAG_W-1:0]  req_tag_q, req_tag_d;
  logic [WORD_W-1:0] req_word_q, req_word_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [TAG_W-1:0]  vic_tag_q, vic_tag_d;
  logic              vic_valid_q, vic_valid_d;
  logic              vic_dirty_q, vic_dirty_d;
  logic [DATA_W-1:0] line_q [LINE_W];
  logic [DATA_W-1:0] line_d [LINE_W];
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              hit_q, hit_d;
  logic              err_q, err_d;

  logic    way_start, way_done, way_to;
  logic    mem_start, mem_done, mem_to;
  way_op_e way_op;

  cache_hs_master #(.TIMEOUT(TIMEOUT)) u_way_hs (
    .clk(clk), .rst(rst), .start(way_start), .ack(way_ack),
    .strobe(way_en), .done(way_done), .timeout(way_to)
  );

  cache_hs_master #(.TIMEOUT(TIMEOUT)) u_mem_hs (
    .clk(clk), .rst(rst), .start(mem_start), .ack(mem_ack),
    .strobe(mem_req), .done(mem_done), .timeout(mem_to)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      req_wr_q    <= 1'b0;
      req_tag_q   <= '0;
      req_word_q  <= '0;
      req_wdata_q <= '0;
      vic_tag_q   <= '0;
      vic_valid_q <= 1'b0;
      vic_dirty_q <= 1'b0;
      fill_q      <= '0;
      rdata_q     <= '0;
      hit_q       <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < LINE_W; i++) line_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      req_wr_q    <= req_wr_d;
      req_tag_q   <= req_tag_d;
      req_word_q  <= req_word_d;
      req_wdata_q <= req_wdata_d;
      vic_tag_q   <= vic_tag_d;
      vic_valid_q <= vic_valid_d;
      vic_dirty_q <= vic_dirty_d;
      fill_q      <= fill_d;
      rdata_q     <= rdata_d;
      hit_q       <= hit_d;
      err_q       <= err_d;
      for (int i = 0; i < LINE_W; i++) line_q[i] <= line_d[i];
    end
  end

  // Each phase advances only on a master's done pulse; the masters themselves
  // hold off a new strobe until the previous ack has fallen.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    req_wr_d    = req_wr_q;
    req_tag_d   = req_tag_q;
    req_word_d  = req_word_q;
    req_wdata_d = req_wdata_q;
    vic_tag_d   = vic_tag_q;
    vic_valid_d = vic_valid_q;
    vic_dirty_d = vic_dirty_q;
    fill_d      = fill_q;
    rdata_d     = rdata_q;
    hit_d       = hit_q;
    err_d       = err_q;
    line_d      = line_q;
    way_start   = 1'b0;
    mem_start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          req_wr_d    = cpu_wr;
          req_tag_d   = cpu_addr[TAG_W+WORD_W-1:WORD_W];
          req_word_d  = cpu_addr[WORD_W-1:0];
          req_wdata_d = cpu_wdata;
          rdata_d     = '0;
          hit_d       = 1'b0;
          err_d       = 1'b0;
          state_d     = S_CMP;
        end
      end
      S_CMP: begin
        way_start = 1'b1;
        if (way_done) begin
          if (way_hit) begin
            rdata_d = way_data_out;
            hit_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            hit_d   = 1'b0;
            word_d  = '0;
            state_d = S_VICT;
          end
        end
      end
      S_VICT: begin
        way_start = 1'b1;
        if (way_done) begin
          line_d[word_q] = way_data_out;
          if (word_q == '0) begin
            vic_tag_d   = way_tag_out;
            vic_valid_d = way_valid_out;
            vic_dirty_d = way_dirty;
          end
          word_d = word_q + WORD_W'(1);
          if (word_q == LAST) state_d = (vic_valid_q && vic_dirty_q) ? S_WB : S_FILL_RD;
        end
      end
      S_WB: begin
        mem_start = 1'b1;
        if (mem_done) begin
          word_d = word_q + WORD_W'(1);
          if (word_q == LAST) state_d = S_FILL_RD;
        end
      end
      S_FILL_RD: begin
        mem_start = 1'b1;
        if (mem_done) begin
          fill_d  = mem_rdata;
          state_d = S_FILL_WR;
        end
      end
      S_FILL_WR: begin
        way_start = 1'b1;
        if (way_done) begin
          word_d  = word_q + WORD_W'(1);
          state_d = (word_q == LAST) ? S_REPLAY : S_FILL_RD;
        end
      end
      S_REPLAY: begin
        way_start = 1'b1;
        if (way_done) begin
          rdata_d = way_data_out;
          if (!way_hit) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!cpu_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if ((way_to || mem_to) && state_q != S_IDLE && state_q != S_DONE) begin
      way_start = 1'b0;
      mem_start = 1'b0;
      err_d     = 1'b1;
      state_d   = S_DONE;
    end
  end

  always_comb begin
    way_op    = ACC_RD;
    way_word  = '0;
    way_tag   = '0;
    way_data  = '0;
    way_valid = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_CMP, S_REPLAY: begin
        way_op   = cmp_op(req_wr_q);
        way_word = req_word_q;
        way_tag  = req_tag_q;
        way_data = req_wdata_q;
      end
      S_VICT: begin
        way_word = word_q;
        way_tag  = req_tag_q;
      end
      S_FILL_WR: begin
        way_op    = ACC_WR;
        way_word  = word_q;
        way_tag   = req_tag_q;
        way_data  = fill_q;
        way_valid = 1'b1;
      end
      S_WB: begin
        mem_wr    = 1'b1;
        mem_addr  = {vic_tag_q, word_q};
        mem_wdata = line_q[word_q];
      end
      S_FILL_RD: mem_addr = {req_tag_q, word_q};
      default: ;
    endcase
  end

  assign way_comp  = (way_op == CMP_RD) || (way_op == CMP_WR);
  assign way_write = (way_op == CMP_WR) || (way_op == ACC_WR);
  assign cpu_ack   = (state_q == S_DONE);
  assign cpu_rdata = cpu_ack ? rdata_q : '0;
  assign cpu_hit   = cpu_ack && hit_q;
  assign cpu_err   = cpu_ack && err_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: directed CPU requests against behavioural
// way and memory responders; a monitor thread checks every cpu_ack response.
module tb_cache_ctrl;

  localparam int TW = 5;
  localparam int WW = 2;
  localparam int DW = 16;
  localparam int TO = 64;
  localparam int AW = TW + WW;

  logic          clk;
  logic          rst;
  logic          cpu_req, cpu_wr, cpu_ack, cpu_hit, cpu_err;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          way_en, way_comp, way_write, way_valid;
  logic [WW-1:0] way_word;
  logic [TW-1:0] way_tag, way_tag_out;
  logic [DW-1:0] way_data, way_data_out;
  logic          way_ack, way_hit, way_dirty, way_valid_out;
  logic          mem_req, mem_wr, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  cache_ctrl #(.TAG_W(TW), .WORD_W(WW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit), .cpu_err(cpu_err),
    .way_en(way_en), .way_comp(way_comp), .way_write(way_write), .way_word(way_word),
    .way_tag(way_tag), .way_data(way_data), .way_valid(way_valid),
    .way_ack(way_ack), .way_hit(way_hit), .way_dirty(way_dirty),
    .way_tag_out(way_tag_out), .way_data_out(way_data_out), .way_valid_out(way_valid_out),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          hit;
    logic          err;
  } exp_t;

  exp_t sb_q[$];

  logic [TW-1:0] m_tag;
  logic          m_valid, m_dirty;
  logic [DW-1:0] m_data[4];
  logic [DW-1:0] mem_arr[128];
  logic          mem_stall;
  logic [AW-1:0] wb_addr_q[$];
  logic [DW-1:0] wb_data_q[$];
  int way_cmds, acc_wr_cnt, mem_rd_cnt, mem_wr_cnt, mem_req_cycles, overlap_cycles;
  int fill_rise_cycle;
  logic prev_ack, prev_fill;
  int n_checks, n_fail;

  function automatic logic [AW-1:0] mk(input logic [TW-1:0] tag, input logic [WW-1:0] w);
    return {tag, w};
  endfunction

  function automatic logic [127:0] all_outs();
    logic [70:0] v;
    v = {cpu_ack, cpu_rdata, cpu_hit, cpu_err, way_en, way_comp, way_write, way_word,
         way_tag, way_data, way_valid, mem_req, mem_wr, mem_addr, mem_wdata};
    return 128'(v);
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Single-line way: compare ops hit on valid+tag, access writes refill the line.
  task automatic way_model();
    forever begin
      @(negedge clk);
      if (way_en && !way_ack) begin
        if (way_comp) begin
          way_hit = m_valid && (m_tag == way_tag);
          if (way_hit && way_write) begin
            m_data[way_word] = way_data;
            m_dirty = 1'b1;
          end
        end else begin
          way_hit = 1'b0;
          if (way_write) begin
            m_data[way_word] = way_data;
            m_tag   = way_tag;
            m_valid = way_valid;
            m_dirty = 1'b0;
            acc_wr_cnt++;
          end
        end
        way_data_out  = m_data[way_word];
        way_tag_out   = m_tag;
        way_valid_out = m_valid;
        way_dirty     = m_dirty;
        way_ack       = 1'b1;
        way_cmds++;
      end else if (!way_en && way_ack) begin
        way_ack = 1'b0;
      end
    end
  endtask

  task automatic mem_model();
    forever begin
      @(negedge clk);
      if (mem_req && !mem_ack) begin
        if (!(mem_stall && !mem_wr)) begin
          if (mem_wr) begin
            mem_arr[mem_addr] = mem_wdata;
            wb_addr_q.push_back(mem_addr);
            wb_data_q.push_back(mem_wdata);
            mem_wr_cnt++;
          end else begin
            mem_rdata = mem_arr[mem_addr];
            mem_rd_cnt++;
          end
          mem_ack = 1'b1;
        end
      end else if (!mem_req && mem_ack) begin
        mem_ack = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (way_en && mem_req) overlap_cycles++;
      if (mem_req) mem_req_cycles++;
      if (mem_req && !mem_wr && !prev_fill) fill_rise_cycle = cycle;
      prev_fill = mem_req && !mem_wr;
      if (cpu_ack && !prev_ack) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_ack: got cpu_ack=1, expected no response");
        end else begin
          e = sb_q.pop_front();
          checkOutput("cpu_rdata", 128'(cpu_rdata), 128'(e.rdata));
          checkOutput("cpu_hit", 128'(cpu_hit), 128'(e.hit));
          checkOutput("cpu_err", 128'(cpu_err), 128'(e.err));
          if (e.err) begin
            checkOutput("timeout_latency", 128'(cycle - fill_rise_cycle), 128'(TO));
            checkOutput("timeout_mem_req_low", 128'(mem_req), 128'(0));
          end
        end
      end
      prev_ack = cpu_ack;
    end
  endtask

  // Issue one request, expect the response through the scoreboard, optionally
  // hold cpu_req after the ack, then confirm the ack clears one cycle after release.
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                               input logic exp_hit, input logic exp_err,
                               input int hold, output int lat);
    int cmds;
    sb_q.push_back('{rdata: exp_rdata, hit: exp_hit, err: exp_err});
    @(negedge clk);
    cpu_wr    = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_req   = 1'b1;
    lat = 0;
    while (!cpu_ack && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    if (!cpu_ack) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL ack_wait: got no cpu_ack after %0d cycles, expected cpu_ack=1", lat);
      void'(sb_q.pop_back());
      cpu_req = 1'b0;
      @(negedge clk);
    end else begin
      cmds = way_cmds;
      repeat (hold) @(negedge clk);
      if (hold > 0) begin
        checkOutput("ack_held", 128'(cpu_ack), 128'(1));
        checkOutput("no_new_way_cmd", 128'(way_cmds - cmds), 128'(0));
      end
      cpu_req = 1'b0;
      @(negedge clk);
      checkOutput("ack_clear", 128'(cpu_ack), 128'(0));
    end
  endtask

  initial begin
    int lat, snap, rd0, wr0, aw0, n;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    way_ack = 1'b0; way_hit = 1'b0; way_dirty = 1'b0; way_tag_out = '0;
    way_data_out = '0; way_valid_out = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; mem_stall = 1'b0;
    way_cmds = 0; acc_wr_cnt = 0; mem_rd_cnt = 0; mem_wr_cnt = 0;
    mem_req_cycles = 0; overlap_cycles = 0; fill_rise_cycle = 0;
    prev_ack = 1'b0; prev_fill = 1'b0; n_checks = 0; n_fail = 0;
    m_tag = '0; m_valid = 1'b0; m_dirty = 1'b0;
    for (int i = 0; i < 4; i++) m_data[i] = '0;
    for (int a = 0; a < 128; a++) mem_arr[a] = DW'(16'h2000 + a);
    fork
      way_model();
      mem_model();
      monitor();
    join_none

    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", all_outs(), 128'(0));
    rst = 1'b0;

    $display("[TB] read hit");
    m_tag = 5'h03; m_valid = 1'b1; m_dirty = 1'b0;
    m_data[0] = 16'h1110; m_data[1] = 16'hBEEF; m_data[2] = 16'h1112; m_data[3] = 16'h1113;
    snap = mem_req_cycles;
    applyStimulus(1'b0, mk(5'h03, 2'd1), '0, 16'hBEEF, 1'b1, 1'b0, 0, lat);
    checkOutput("t1_no_mem_req", 128'(mem_req_cycles - snap), 128'(0));
    checkOutput("t1_latency", 128'(lat), 128'(3));

    $display("[TB] clean miss");
    for (int w = 0; w < 4; w++) mem_arr[mk(5'h07, 2'(w))] = DW'(16'h1000 + w);
    rd0 = mem_rd_cnt; wr0 = mem_wr_cnt; aw0 = acc_wr_cnt;
    applyStimulus(1'b0, mk(5'h07, 2'd2), '0, 16'h1002, 1'b0, 1'b0, 0, lat);
    checkOutput("t2_mem_reads", 128'(mem_rd_cnt - rd0), 128'(4));
    checkOutput("t2_mem_writes", 128'(mem_wr_cnt - wr0), 128'(0));
    checkOutput("t2_way_acc_writes", 128'(acc_wr_cnt - aw0), 128'(4));

    $display("[TB] dirty miss");
    m_tag = 5'h01; m_valid = 1'b1; m_dirty = 1'b1;
    for (int i = 0; i < 4; i++) m_data[i] = DW'(16'hAAA0 + i);
    wb_addr_q.delete(); wb_data_q.delete();
    applyStimulus(1'b1, mk(5'h09, 2'd0), 16'h5555, 16'h5555, 1'b0, 1'b0, 0, lat);
    checkOutput("t3_wb_count", 128'(wb_addr_q.size()), 128'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < wb_addr_q.size()) begin
        checkOutput("t3_wb_addr", 128'(wb_addr_q[i]), 128'(mk(5'h01, 2'(i))));
        checkOutput("t3_wb_data", 128'(wb_data_q[i]), 128'(DW'(16'hAAA0 + i)));
      end
    end
    applyStimulus(1'b0, mk(5'h09, 2'd0), '0, 16'h5555, 1'b1, 1'b0, 0, lat);

    $display("[TB] fill timeout");
    mem_stall = 1'b1;
    applyStimulus(1'b0, mk(5'h0A, 2'd0), '0, 16'h0000, 1'b0, 1'b1, 0, lat);
    mem_stall = 1'b0;

    $display("[TB] reset during write-back");
    wr0 = mem_wr_cnt;
    @(negedge clk);
    cpu_wr = 1'b0; cpu_addr = mk(5'h0B, 2'd3); cpu_req = 1'b1;
    n = 0;
    while ((mem_wr_cnt - wr0) < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t5_reached_wb", 128'(mem_wr_cnt - wr0), 128'(2));
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_reset_outputs", all_outs(), 128'(0));
    rst = 1'b0;
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    wb_addr_q.delete(); wb_data_q.delete();
    applyStimulus(1'b0, mk(5'h0C, 2'd1), '0, 16'h2031, 1'b0, 1'b0, 0, lat);
    checkOutput("t5_wb_after_reset", 128'(wb_addr_q.size()), 128'(4));

    $display("[TB] cpu_req held after ack");
    applyStimulus(1'b0, mk(5'h0C, 2'd1), '0, 16'h2031, 1'b1, 1'b0, 5, lat);
    checkOutput("t6_latency", 128'(lat), 128'(3));

    repeat (3) @(negedge clk);
    checkOutput("no_way_mem_overlap", 128'(overlap_cycles), 128'(0));
    checkOutput("scoreboard_drained", 128'(sb_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
